// File: rtl/conv_window_sched.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_sched
// Description : Job sequencer for the 3x3 conv datapath. Gathers each valid
//               3x3 window of a row-major 8-bit image from input SRAM with
//               nine byte reads, issues it to conv with the held weights and
//               writes every result to output SRAM in raster order.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_sched #(
   parameter int ADDR_W = 14,
   parameter int DIM_W  = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DIM_W-1:0]  cfg_h,
   input  logic [DIM_W-1:0]  cfg_w,
   input  logic [ADDR_W-1:0] cfg_in_base,
   input  logic [ADDR_W-1:0] cfg_out_base,
   input  logic              w_load,
   input  logic [71:0]       w_data,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [7:0]        mem_rd_data,
   output logic              conv_i_valid,
   output logic [71:0]       conv_i_tensor,
   output logic [71:0]       conv_w_tensor,
   input  logic              conv_o_valid,
   input  logic [7:0]        conv_o_tensor,
   output logic              out_wr_en,
   output logic [ADDR_W-1:0] out_wr_addr,
   output logic [7:0]        out_wr_data
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      LAST  = 3'd2,
      ISSUE = 3'd3,
      DRAIN = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t            r_state;
   logic [DIM_W-1:0]  r_h;
   logic [DIM_W-1:0]  r_w;
   logic [DIM_W-1:0]  r_ox;
   logic [DIM_W-1:0]  r_oy;
   logic [ADDR_W-1:0] r_out_base;
   logic [ADDR_W-1:0] r_out_idx;
   logic [ADDR_W-1:0] r_row_base;   // in_base + oy*W
   logic [ADDR_W-1:0] r_win_base;   // in_base + oy*W + ox
   logic [3:0]        r_k;          // tap currently on the read port
   logic [63:0]       r_shadow;     // window bytes 0..7 while gathering

   logic              w_last_col;
   logic              w_last_row;
   logic              w_wr;
   logic [ADDR_W-1:0] w_next_win;

   // Address of tap k relative to a window origin: base + r*W + c.
   function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [DIM_W-1:0]  w,
                                                  input logic [3:0]        k);
      logic [ADDR_W-1:0] w_ext;
      logic [ADDR_W-1:0] roff;
      logic [ADDR_W-1:0] coff;
      w_ext = ADDR_W'(w);
      roff  = '0;
      coff  = '0;
      case (k)
         4'd0: begin roff = '0;         coff = ADDR_W'(0); end
         4'd1: begin roff = '0;         coff = ADDR_W'(1); end
         4'd2: begin roff = '0;         coff = ADDR_W'(2); end
         4'd3: begin roff = w_ext;      coff = ADDR_W'(0); end
         4'd4: begin roff = w_ext;      coff = ADDR_W'(1); end
         4'd5: begin roff = w_ext;      coff = ADDR_W'(2); end
         4'd6: begin roff = w_ext << 1; coff = ADDR_W'(0); end
         4'd7: begin roff = w_ext << 1; coff = ADDR_W'(1); end
         4'd8: begin roff = w_ext << 1; coff = ADDR_W'(2); end
         default: begin roff = '0;      coff = '0;         end
      endcase
      return base + roff + coff;
   endfunction

   assign w_last_col = (r_ox == r_w - DIM_W'(3));
   assign w_last_row = (r_oy == r_h - DIM_W'(3));
   assign w_next_win = w_last_col ? (r_row_base + ADDR_W'(r_w))
                                  : (r_win_base + ADDR_W'(1));

   // Writeback is a pass-through: results are written as they arrive while busy.
   assign w_wr        = conv_o_valid & busy;
   assign out_wr_en   = w_wr;
   assign out_wr_addr = r_out_base + r_out_idx;
   assign out_wr_data = conv_o_tensor;

   // Sequencer FSM with registered strobes, window gather and output index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_h           <= '0;
         r_w           <= '0;
         r_ox          <= '0;
         r_oy          <= '0;
         r_out_base    <= '0;
         r_out_idx     <= '0;
         r_row_base    <= '0;
         r_win_base    <= '0;
         r_k           <= '0;
         r_shadow      <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         mem_rd_en     <= 1'b0;
         mem_rd_addr   <= '0;
         conv_i_valid  <= 1'b0;
         conv_i_tensor <= '0;
         conv_w_tensor <= '0;
      end else begin
         if (w_wr) begin
            r_out_idx <= r_out_idx + ADDR_W'(1);
         end
         case (r_state)
            IDLE: begin
               if (w_load) begin
                  conv_w_tensor <= w_data;
               end
               if (start) begin
                  if (cfg_h >= DIM_W'(3) && cfg_w >= DIM_W'(3)) begin
                     r_h         <= cfg_h;
                     r_w         <= cfg_w;
                     r_ox        <= '0;
                     r_oy        <= '0;
                     r_out_base  <= cfg_out_base;
                     r_out_idx   <= '0;
                     r_row_base  <= cfg_in_base;
                     r_win_base  <= cfg_in_base;
                     r_k         <= '0;
                     mem_rd_en   <= 1'b1;
                     mem_rd_addr <= cfg_in_base;
                     busy        <= 1'b1;
                     r_state     <= READ;
                  end else begin
                     done    <= 1'b1;
                     r_state <= DONE;
                  end
               end
            end
            READ: begin
               // Byte k-1 arrives while tap k is being read.
               for (int i = 0; i < 8; i++) begin
                  if (r_k == 4'(i + 1)) begin
                     r_shadow[8*i +: 8] <= mem_rd_data;
                  end
               end
               if (r_k == 4'd8) begin
                  mem_rd_en <= 1'b0;
                  r_state   <= LAST;
               end else begin
                  r_k         <= r_k + 4'd1;
                  mem_rd_addr <= tap_addr(r_win_base, r_w, r_k + 4'd1);
               end
            end
            LAST: begin
               conv_i_tensor <= {mem_rd_data, r_shadow};
               conv_i_valid  <= 1'b1;
               r_state       <= ISSUE;
            end
            ISSUE: begin
               conv_i_valid <= 1'b0;
               if (w_last_col && w_last_row) begin
                  r_state <= DRAIN;
               end else begin
                  if (w_last_col) begin
                     r_ox       <= '0;
                     r_oy       <= r_oy + DIM_W'(1);
                     r_row_base <= r_row_base + ADDR_W'(r_w);
                  end else begin
                     r_ox <= r_ox + DIM_W'(1);
                  end
                  r_win_base  <= w_next_win;
                  r_k         <= '0;
                  mem_rd_en   <= 1'b1;
                  mem_rd_addr <= tap_addr(w_next_win, r_w, 4'd0);
                  r_state     <= READ;
               end
            end
            DRAIN: begin
               if (conv_o_valid) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               done    <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_window_sched
// Description : Directed self-checking bench for conv_window_sched with an
//               input SRAM model, a 2-cycle conv model and a write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_sched;

   localparam int ADDR_W = 14;
   localparam int DIM_W  = 7;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [DIM_W-1:0]  cfg_h = '0;
   logic [DIM_W-1:0]  cfg_w = '0;
   logic [ADDR_W-1:0] cfg_in_base = '0;
   logic [ADDR_W-1:0] cfg_out_base = '0;
   logic              w_load = 1'b0;
   logic [71:0]       w_data = '0;
   logic              busy, done, mem_rd_en, conv_i_valid, out_wr_en;
   logic [ADDR_W-1:0] mem_rd_addr, out_wr_addr;
   logic [7:0]        mem_rd_data, out_wr_data;
   logic [71:0]       conv_i_tensor, conv_w_tensor;
   logic              conv_o_valid;
   logic [7:0]        conv_o_tensor;

   conv_window_sched #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_h(cfg_h), .cfg_w(cfg_w),
      .cfg_in_base(cfg_in_base), .cfg_out_base(cfg_out_base),
      .w_load(w_load), .w_data(w_data), .busy(busy), .done(done),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .conv_i_valid(conv_i_valid), .conv_i_tensor(conv_i_tensor),
      .conv_w_tensor(conv_w_tensor), .conv_o_valid(conv_o_valid),
      .conv_o_tensor(conv_o_tensor), .out_wr_en(out_wr_en),
      .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data)
   );

   always #5 clk = ~clk;

   // ---------------- models ----------------
   logic [7:0] mem [0:16383];
   logic       mv1, mv2, stray_v = 1'b0;
   logic [7:0] md1, md2;

   function automatic logic [7:0] conv_fn(input logic [71:0] t, input logic [71:0] w);
      int s = 0;
      for (int k = 0; k < 9; k++) s += int'(t[8*k +: 8]) * int'(w[8*k +: 8]);
      return 8'(s >>> 8);
   endfunction

   function automatic logic [7:0] exp_conv(input int base, input int wd, input int oy,
                                           input int ox, input logic [71:0] wt);
      int s = 0;
      for (int k = 0; k < 9; k++)
         s += int'(mem[base + (oy + k/3)*wd + ox + k%3]) * int'(wt[8*k +: 8]);
      return 8'(s >>> 8);
   endfunction

   always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : 8'h5A;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mv1 <= 1'b0; mv2 <= 1'b0; md1 <= '0; md2 <= '0;
      end else begin
         mv1 <= conv_i_valid;
         md1 <= conv_fn(conv_i_tensor, conv_w_tensor);
         mv2 <= mv1;
         md2 <= md1;
      end
   end
   assign conv_o_valid  = mv2 | stray_v;
   assign conv_o_tensor = stray_v ? 8'h77 : md2;

   // ---------------- scoreboard / monitor ----------------
   typedef struct {int addr; int data; int cyc;} wr_t;
   wr_t exp_q[$];
   int  rd_addr_q[$], rd_cyc_q[$], issue_q[$];
   int  tests = 0, fails = 0;
   int  cyc = 0, t0 = 0;
   int  done_cyc = -1, done_cnt = 0, busy_first = -1, busy_last = -1, unexp = 0;
   bit  job_done = 1'b0;

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         int rel;
         rel = cyc - t0;
         if (out_wr_en) begin
            if (exp_q.size() == 0) unexp++;
            else begin
               wr_t e;
               e = exp_q.pop_front();
               check("wr_addr", 72'(out_wr_addr), 72'(e.addr));
               check("wr_data", 72'(out_wr_data), 72'(e.data));
               check("wr_cycle", 72'(rel), 72'(e.cyc));
            end
         end
         if (mem_rd_en) begin
            rd_addr_q.push_back(int'(mem_rd_addr));
            rd_cyc_q.push_back(rel);
         end
         if (conv_i_valid) issue_q.push_back(rel);
         if (done) begin done_cnt++; done_cyc = rel; job_done = 1'b1; end
         if (busy) begin
            if (busy_first < 0) busy_first = rel;
            busy_last = rel;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic start_job(input int h, input int wd, input int inb, input int outb);
      tick();
      cfg_h = DIM_W'(h); cfg_w = DIM_W'(wd);
      cfg_in_base = ADDR_W'(inb); cfg_out_base = ADDR_W'(outb);
      start = 1'b1;
      t0 = cyc;
      rd_addr_q.delete(); rd_cyc_q.delete(); issue_q.delete();
      done_cyc = -1; done_cnt = 0; busy_first = -1; busy_last = -1; job_done = 1'b0;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      for (int i = 0; i < budget && !job_done; i++) @(posedge clk);
      #2;
      check(tag, 72'(job_done), 72'(1));
      tick();
   endtask

   task automatic load_w(input logic [71:0] wt);
      tick();
      w_load = 1'b1; w_data = wt;
      tick();
      w_load = 1'b0;
   endtask

   task automatic smoke();
      logic [71:0] wt;
      wt = {9{8'd16}};
      load_w(wt);
      exp_q.push_back('{addr: 'h100, data: int'(exp_conv(0, 3, 0, 0, wt)), cyc: 13});
      start_job(3, 3, 0, 'h100);
      wait_done("smoke_timeout", 60);
      check("smoke_done_cyc", 72'(done_cyc), 72'(14));
      check("smoke_rd_count", 72'(rd_addr_q.size()), 72'(9));
      if (rd_addr_q.size() == 9)
         for (int k = 0; k < 9; k++) begin
            check("smoke_rd_addr", 72'(rd_addr_q[k]), 72'(k));
            check("smoke_rd_cyc", 72'(rd_cyc_q[k]), 72'(1 + k));
         end
      check("smoke_issue_count", 72'(issue_q.size()), 72'(1));
      if (issue_q.size() == 1) check("smoke_issue_cyc", 72'(issue_q[0]), 72'(11));
      check("smoke_busy_first", 72'(busy_first), 72'(1));
      check("smoke_busy_last", 72'(busy_last), 72'(13));
      check("smoke_wr_left", 72'(exp_q.size()), 72'(0));
      check("smoke_unexp", 72'(unexp), 72'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic [71:0] wr;
      for (int a = 0; a < 16384; a++) mem[a] = 8'h00;
      for (int a = 0; a < 9; a++) mem[a] = 8'd16;
      for (int a = 'h40; a < 'h60; a++) mem[a] = 8'((a * 37 + 11) & 255);
      for (int k = 0; k < 9; k++) wr[8*k +: 8] = 8'(k * 13 + 5);

      // Reset values
      repeat (3) tick();
      check("rst_busy", 72'(busy), 72'(0));
      check("rst_done", 72'(done), 72'(0));
      check("rst_rd_en", 72'(mem_rd_en), 72'(0));
      check("rst_rd_addr", 72'(mem_rd_addr), 72'(0));
      check("rst_i_valid", 72'(conv_i_valid), 72'(0));
      check("rst_i_tensor", conv_i_tensor, 72'(0));
      check("rst_w_tensor", conv_w_tensor, 72'(0));
      check("rst_wr_en", 72'(out_wr_en), 72'(0));
      check("rst_wr_addr", 72'(out_wr_addr), 72'(0));
      rst_n = 1'b1;
      tick();

      // Stray result while idle
      stray_v = 1'b1;
      #1 check("stray_wr_en", 72'(out_wr_en), 72'(0));
      tick();
      stray_v = 1'b0;

      // 3x3 smoke (also checks write index unaffected by the stray result)
      smoke();

      // Degenerate configuration
      start_job(2, 8, 0, 'h300);
      wait_done("degen_timeout", 10);
      check("degen_done_cyc", 72'(done_cyc), 72'(1));
      check("degen_rd_count", 72'(rd_addr_q.size()), 72'(0));
      check("degen_busy", 72'(busy_first), 72'(-1));
      check("degen_unexp", 72'(unexp), 72'(0));

      // 4x5 raster with ignored start/w_load mid-job
      load_w(wr);
      for (int n = 0; n < 6; n++)
         exp_q.push_back('{addr: 'h200 + n, data: int'(exp_conv('h40, 5, n/3, n%3, wr)),
                           cyc: 13 + 11*n});
      start_job(4, 5, 'h40, 'h200);
      repeat (19) tick();
      start = 1'b1; w_load = 1'b1; w_data = {9{8'hFF}};
      cfg_h = DIM_W'(3); cfg_w = DIM_W'(3);
      tick();
      start = 1'b0; w_load = 1'b0;
      wait_done("raster_timeout", 100);
      check("raster_done_cyc", 72'(done_cyc), 72'(69));
      check("raster_done_cnt", 72'(done_cnt), 72'(1));
      check("raster_busy_last", 72'(busy_last), 72'(68));
      check("raster_rd_count", 72'(rd_addr_q.size()), 72'(54));
      if (rd_addr_q.size() == 54)
         for (int k = 0; k < 9; k++) begin
            check("raster_w3_addr", 72'(rd_addr_q[27 + k]), 72'('h40 + (1 + k/3)*5 + k%3));
            check("raster_w3_cyc", 72'(rd_cyc_q[27 + k]), 72'(34 + k));
         end
      check("raster_issue_count", 72'(issue_q.size()), 72'(6));
      check("raster_wr_left", 72'(exp_q.size()), 72'(0));
      check("raster_unexp", 72'(unexp), 72'(0));
      check("raster_w_kept", conv_w_tensor, wr);
      load_w({9{8'hFF}});
      tick();
      check("w_load_idle", conv_w_tensor, {9{8'hFF}});

      // Reset in the middle of a 4x5 job
      for (int n = 0; n < 2; n++)
         exp_q.push_back('{addr: 'h200 + n, data: int'(exp_conv('h40, 5, n/3, n%3, {9{8'hFF}})),
                           cyc: 13 + 11*n});
      start_job(4, 5, 'h40, 'h200);
      repeat (29) tick();
      rst_n = 1'b0;
      #1;
      check("abort_busy", 72'(busy), 72'(0));
      check("abort_done", 72'(done), 72'(0));
      check("abort_rd_en", 72'(mem_rd_en), 72'(0));
      check("abort_rd_addr", 72'(mem_rd_addr), 72'(0));
      check("abort_i_valid", 72'(conv_i_valid), 72'(0));
      check("abort_i_tensor", conv_i_tensor, 72'(0));
      check("abort_w_tensor", conv_w_tensor, 72'(0));
      check("abort_wr_addr", 72'(out_wr_addr), 72'(0));
      check("abort_wr_left", 72'(exp_q.size()), 72'(0));
      exp_q.delete();
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (30) tick();
      check("abort_no_done", 72'(done_cnt), 72'(0));
      check("abort_unexp", 72'(unexp), 72'(0));

      // Fresh job after the abort
      smoke();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/conv_window_sched.md
# conv_window_sched

Job sequencer for the 3x3 `conv` datapath. On a start command it walks a row-major 8-bit feature map in input SRAM and gathers each 3x3 window with nine single-byte reads. It issues every window to `conv` together with a held weight tensor, and writes each result to output SRAM at an address it tracks itself. Convolution is valid mode only (no padding, stride 1), giving (H-2)x(W-2) outputs per job.

## Interface

Parameters:
- ADDR_W, 14, SRAM address width (input and output).
- DIM_W, 7, width of the height/width config fields.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  job start pulse; ignored while busy.
- cfg_h, cfg_w  in  DIM_W  image height and width; sampled on accepted start.
- cfg_in_base, cfg_out_base  in  ADDR_W  SRAM base addresses; sampled on accepted start.
- w_load  in  1  load w_data into the weight register; honoured only while idle.
- w_data  in  72  weights, tap (r,c) in bits [8*(3r+c)+:8].
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end.
- mem_rd_en  out  1  input SRAM read strobe.
- mem_rd_addr  out  ADDR_W  input SRAM address.
- mem_rd_data  in  8  read data, valid exactly one cycle after mem_rd_en.
- conv_i_valid  out  1  window-issue strobe to `conv`.
- conv_i_tensor  out  72  window bytes, same packing as w_data.
- conv_w_tensor  out  72  weight register, driven continuously.
- conv_o_valid  in  1  result strobe from `conv`.
- conv_o_tensor  in  8  result from `conv`.
- out_wr_en  out  1  output SRAM write strobe.
- out_wr_addr  out  ADDR_W  output SRAM address.
- out_wr_data  out  8  output SRAM data.

## Operation

- FSM states: IDLE, READ, LAST, ISSUE, DRAIN, DONE.
- **IDLE**
  - start with cfg_h>=3 and cfg_w>=3: latch config, clear counters, go to READ, set busy.
  - start with cfg_h<3 or cfg_w<3: go to DONE. No reads or writes occur.
- **READ** (9 cycles)
  - mem_rd_en=1 with tap index k=0..8 in order, r=k/3, c=k%3.
  - Address = in_base + (oy+r)*W + (ox+c), truncated to ADDR_W.
  - Byte k is captured into window byte k on the cycle after its read.
- **LAST** (1 cycle): captures byte 8.
- **ISSUE** (1 cycle)
  - conv_i_valid=1; conv_i_tensor holds the complete window.
  - Then advance ox. On ox==W-3, wrap ox to 0 and increment oy.
  - If this was the final window (oy==H-3 and ox==W-3), go to DRAIN; otherwise go to READ.
- **DRAIN**: waits for the final conv_o_valid, then goes to DONE.
- **DONE** (1 cycle): done=1, busy=0 next cycle, return to IDLE.
- Writeback runs in every state:
  - out_wr_en = conv_o_valid & busy.
  - out_wr_data = conv_o_tensor.
  - out_wr_addr = out_base + out_idx.
  - out_idx increments after each write; raster order matches issue order.
- At most one window is outstanding in `conv`, so no output buffering is needed.
- conv_i_tensor is a register and keeps its last window between issues. conv_w_tensor is stable for the whole job.
- conv_o_valid while not busy is ignored: no write, no counter change.

## Timing

- Reset values: busy=0, done=0, mem_rd_en=0, conv_i_valid=0, out_wr_en=0, all address/tensor outputs 0, weight register 0, state IDLE.
- Reset mid-job aborts immediately. No done pulse follows; the next start begins a fresh job.
- Counting start as cycle 0:
  - Window n reads occupy cycles 1+11n .. 9+11n.
  - Window n issues at cycle 11+11n.
  - Window n is written at 13+11n (conv latency 2).
- With N=(H-2)(W-2) windows, done is high at cycle 14+11(N-1) and busy is high from cycle 1 through cycle 13+11(N-1).
- Degenerate job (H<3 or W<3): done at cycle 1, busy stays 0.
- start in the same cycle as done: ignored.
- w_load together with an accepted start: the load is applied, and the job uses the new weights.

## Test plan

- **3x3 smoke test**: image all 16, w_load all 16, start with H=W=3, in_base=0, out_base=0x100.
  - Reads hit addresses 0..8 in cycles 1..9; conv_i_valid fires at cycle 11.
  - One write at cycle 13: addr 0x100, data 9 (sum 2304, >>8).
  - done at cycle 14.
- **4x5 raster**: start with H=4, W=5, in_base=0x40, out_base=0x200.
  - 6 writes to 0x200..0x205.
  - Window 3 read addresses: 0x45, 0x46, 0x47, 0x4A, 0x4B, 0x4C, 0x4F, 0x50, 0x51.
  - done at cycle 14+55=69.
- **Degenerate config**: start with H=2, W=8 -> done=1 at cycle 1, no mem_rd_en, no out_wr_en.
- **Ignored inputs while busy**: pulse start and w_load (w_data=all 0xFF) mid-job.
  - The job is unaltered and conv_w_tensor is unchanged.
  - After done, w_load takes effect.
- **Reset mid-job**: deassert rst_n at cycle 30 of the 4x5 job.
  - All outputs reach reset values at once and no done pulse follows.
  - A fresh 3x3 job then completes per scenario 1.
- **Stray result**: conv_o_valid=1 while idle -> no out_wr_en. A following job still writes starting at out_base.
